sim_intf: RTL and testbench
===========================

SIM_INTF -- requirements
Module: sim_intf

Interface
REQ-001 Parameter DEPTH, default 16: number of entries in the expected-execution trace.
REQ-002 Parameter BASE_PC, default 64'h0000_0000_0000_1000: PC of trace entry 0.
REQ-003 Port clk  input  1: single clock; all state changes on rising edge.
REQ-004 Port rst  input  1: reset, asynchronous, active-high.
REQ-005 Port pc_try  input  64: PC proposed by the core for the current cycle, sampled at rising clk.
REQ-006 Port pc_factual  output  64: expected PC; meaningful when miss=1.
REQ-007 Port inst  output  32: instruction fetched at the matched PC; meaningful when miss=0.
REQ-008 Port miss  output  1: 1 = last sampled pc_try did not match the expected PC.

Function
REQ-009 Block SHALL hold a trace table of DEPTH entries {pc[63:0], inst[31:0]} and a trace pointer ptr, range 0..DEPTH.
REQ-010 Default table entry i SHALL be pc = BASE_PC + 4*i and inst = 32'h0000_0013 | (i << 7), i.e. addi xi,x0,0, with i taken modulo 32 in the rd field.
REQ-011 Each rising clk with ptr < DEPTH, pc_try SHALL be compared on all 64 bits with table[ptr].pc.
REQ-012 On match: miss <= 0, inst <= table[ptr].inst, pc_factual <= table[ptr].pc, ptr <= ptr + 1.
REQ-013 On mismatch: miss <= 1, pc_factual <= table[ptr].pc, inst <= 0, ptr unchanged; the core may retry any number of cycles.
REQ-014 Outputs SHALL be registered, updating one cycle after pc_try is sampled and stable until the next rising clk.
REQ-015 Trace exhausted (ptr == DEPTH): every cycle SHALL give miss <= 1, pc_factual <= 64'hFFFF_FFFF_FFFF_FFFF, inst <= 0; ptr saturates.
REQ-016 A pc_try of all-ones SHALL never count as a hit, including when the trace is exhausted.
REQ-017 pc_try must not be X/Z; any unknown bit SHALL be treated as a mismatch (miss=1).
REQ-018 There is no handshake; a comparison occurs every cycle that rst is low.

Reset
REQ-019 Asserting rst SHALL immediately force ptr = 0, miss = 0, inst = 32'h0, and pc_factual = BASE_PC, independent of clk.
REQ-020 Reset asserted mid-trace SHALL discard progress; the first cycle after release compares against entry 0.
REQ-021 No comparison SHALL occur on a rising clk while rst is high.

Structure
REQ-022 Package sim_intf_pkg SHALL hold trace_entry_t {pc, inst}, PC_W=64, INST_W=32, PC_END=all-ones, and the default-trace generator function.
REQ-023 Sub-module sim_intf_trace_rom SHALL provide combinational read of table[ptr] by index. sim_intf SHALL hold the pointer, the comparator and the output registers.

Verification
REQ-024 Reset, then pc_try=0x0 -> miss=1, pc_factual=0x1000.
REQ-025 Then 0x1000, 0x1004 -> miss=0, inst=0x00000013, then 0x00000093.
REQ-026 Then 0xAAAA1008, 0xBBBB1008 -> miss=1, pc_factual=0x1008 both times; then 0x1008 -> miss=0, inst=0x00000113; then 0x100C -> inst=0x00000193.
REQ-027 Then 0xCCCC1010, 0xDDDD1010 -> miss=1, pc_factual=0x1010; then 0x1010 -> miss=0, inst=0x00000213.
REQ-028 Sequentially hit all 16 entries, then pc_try=0x1040 -> miss=1, pc_factual=all-ones, repeated every cycle.
REQ-029 Assert rst asynchronously after 3 hits -> outputs at reset values at once; after release, pc_try=0x1000 -> miss=0, inst=0x00000013.

Source files
------------

// File: rtl/sim_intf_pkg.sv
// Shared types, widths and the default expected-execution trace generator
// for the simulated core interface.
package sim_intf_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0]   PC_END   = {PC_W{1'b1}};
    localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [INST_W-1:0] inst;
    } trace_entry_t;

    // Entry idx is "addi x(idx mod 32), x0, 0" at base + 4*idx.
    function automatic trace_entry_t gen_entry(input logic [PC_W-1:0] base,
                                               input logic [31:0]     idx);
        trace_entry_t e;
        e.pc   = base + {idx, 2'b00};
        e.inst = INST_NOP | {20'd0, idx[4:0], 7'd0};
        return e;
    endfunction

endpackage

// File: rtl/sim_intf_trace_rom.sv
// Combinational expected-trace table: returns the entry at idx_i, or an
// end-of-trace marker for indices at or beyond DEPTH.
module sim_intf_trace_rom
    import sim_intf_pkg::*;
#(
    parameter int              DEPTH   = 16,
    parameter logic [PC_W-1:0] BASE_PC = 64'h0000_0000_0000_1000,
    parameter int              IDX_W   = $clog2(DEPTH + 1)
) (
    input  logic [IDX_W-1:0] idx_i,
    output trace_entry_t     entry_o
);

    // Generate the table entry on the fly from its index.
    always_comb begin
        entry_o = '{pc: PC_END, inst: '0};
        if (idx_i < IDX_W'(DEPTH)) begin
            entry_o = gen_entry(BASE_PC, 32'(idx_i));
        end else begin
            entry_o = '{pc: PC_END, inst: '0};
        end
    end

endmodule

// File: rtl/sim_intf.sv
// Checks the PC proposed by the core each cycle against the expected trace,
// returning the instruction on a hit or the expected PC on a miss.
module sim_intf
    import sim_intf_pkg::*;
#(
    parameter int              DEPTH   = 16,
    parameter logic [PC_W-1:0] BASE_PC = 64'h0000_0000_0000_1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PC_W-1:0]   pc_try,
    output logic [PC_W-1:0]   pc_factual,
    output logic [INST_W-1:0] inst,
    output logic              miss
);

    localparam int PTR_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PC_W-1:0]   pc_factual_q, pc_factual_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              miss_q, miss_d;
    trace_entry_t      cur_s;
    logic              hit_s;

    sim_intf_trace_rom #(
        .DEPTH  (DEPTH),
        .BASE_PC(BASE_PC),
        .IDX_W  (PTR_W)
    ) u_rom (
        .idx_i  (ptr_q),
        .entry_o(cur_s)
    );

    // An all-ones PC is the end marker and is never accepted as a hit; an
    // unknown bit makes the equality unknown, which falls to the miss branch.
    assign hit_s = (pc_try == cur_s.pc) && (pc_try != PC_END);

    // Next-state: saturate when exhausted, advance on hit, hold on miss.
    always_comb begin
        ptr_d        = ptr_q;
        pc_factual_d = pc_factual_q;
        inst_d       = inst_q;
        miss_d       = miss_q;
        if (ptr_q == PTR_W'(DEPTH)) begin
            miss_d       = 1'b1;
            pc_factual_d = PC_END;
            inst_d       = '0;
        end else if (hit_s) begin
            miss_d       = 1'b0;
            pc_factual_d = cur_s.pc;
            inst_d       = cur_s.inst;
            ptr_d        = ptr_q + PTR_W'(1);
        end else begin
            miss_d       = 1'b1;
            pc_factual_d = cur_s.pc;
            inst_d       = '0;
        end
    end

    // Pointer and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q        <= '0;
            pc_factual_q <= BASE_PC;
            inst_q       <= '0;
            miss_q       <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            pc_factual_q <= pc_factual_d;
            inst_q       <= inst_d;
            miss_q       <= miss_d;
        end
    end

    assign pc_factual = pc_factual_q;
    assign inst       = inst_q;
    assign miss       = miss_q;

endmodule

// File: tb/tb_sim_intf.sv
// Directed self-checking bench for sim_intf with hand-computed expectations.
module tb_sim_intf;

    logic        clk;
    logic        rst;
    logic [63:0] pc_try;
    logic [63:0] pc_factual;
    logic [31:0] inst;
    logic        miss;

    int total;
    int bad;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    sim_intf dut (
        .clk       (clk),
        .rst       (rst),
        .pc_try    (pc_try),
        .pc_factual(pc_factual),
        .inst      (inst),
        .miss      (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Present a PC, let one rising edge sample it, then look 1 time unit later.
    task automatic step(input logic [63:0] pc);
        pc_try = pc;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_hit(input string tag, input logic [63:0] pc, input logic [31:0] exp_inst);
        step(pc);
        check({tag, ".miss"}, {63'd0, miss}, 64'd0);
        check({tag, ".inst"}, {32'd0, inst}, {32'd0, exp_inst});
        check({tag, ".pcf"}, pc_factual, pc);
    endtask

    task automatic expect_miss(input string tag, input logic [63:0] pc, input logic [63:0] exp_pcf);
        step(pc);
        check({tag, ".miss"}, {63'd0, miss}, 64'd1);
        check({tag, ".pcf"}, pc_factual, exp_pcf);
        check({tag, ".inst"}, {32'd0, inst}, 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".miss"}, {63'd0, miss}, 64'd0);
        check({tag, ".inst"}, {32'd0, inst}, 64'd0);
        check({tag, ".pcf"}, pc_factual, 64'h1000);
    endtask

    logic [31:0] exp_tab [16] = '{
        32'h0000_0013, 32'h0000_0093, 32'h0000_0113, 32'h0000_0193,
        32'h0000_0213, 32'h0000_0293, 32'h0000_0313, 32'h0000_0393,
        32'h0000_0413, 32'h0000_0493, 32'h0000_0513, 32'h0000_0593,
        32'h0000_0613, 32'h0000_0693, 32'h0000_0713, 32'h0000_0793
    };

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        pc_try = 64'h1000;
        repeat (2) @(posedge clk);
        #1;
        // pc_try matches entry 0 but rst is high: nothing may be compared.
        check_reset_vals("rst_hold");
        rst = 1'b0;

        expect_miss("first_zero", 64'h0, 64'h1000);
        expect_hit ("hit0", 64'h1000, 32'h0000_0013);
        expect_hit ("hit1", 64'h1004, 32'h0000_0093);
        expect_miss("bad_a", 64'hAAAA_1008, 64'h1008);
        expect_miss("bad_b", 64'hBBBB_1008, 64'h1008);
        expect_hit ("hit2", 64'h1008, 32'h0000_0113);
        expect_hit ("hit3", 64'h100C, 32'h0000_0193);
        expect_miss("bad_c", 64'hCCCC_1010, 64'h1010);
        expect_miss("bad_d", 64'hDDDD_1010, 64'h1010);
        expect_miss("ones_mid", ONES, 64'h1010);
        expect_miss("low_bit", 64'h1011, 64'h1010);
        expect_hit ("hit4", 64'h1010, 32'h0000_0213);

        for (int i = 5; i < 16; i++) begin
            expect_hit($sformatf("hit%0d", i), 64'h1000 + 64'(4 * i), exp_tab[i]);
        end

        for (int k = 0; k < 3; k++) begin
            expect_miss($sformatf("exhaust%0d", k), 64'h1040, ONES);
        end
        expect_miss("exhaust_ones", ONES, ONES);
        expect_miss("exhaust_first", 64'h1000, ONES);

        // Restart, make three hits, then reset asynchronously mid-cycle.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_hit("re_hit0", 64'h1000, 32'h0000_0013);
        expect_hit("re_hit1", 64'h1004, 32'h0000_0093);
        expect_hit("re_hit2", 64'h1008, 32'h0000_0113);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        expect_hit("post_rst0", 64'h1000, 32'h0000_0013);
        expect_hit("post_rst1", 64'h1004, 32'h0000_0093);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
